// File: rtl/alu_instr_sequencer_if.sv
// alu_instr_sequencer_if
//   Groups the instruction sequencer's handshake inputs and its datapath
//   control strobes into one bundle.
//   master : the sequencer. It samples start/IR/mem_ready and drives every strobe.
//   slave  : the datapath or bench side. It drives start/IR/mem_ready and
//            receives the strobes.
//   Signals:
//     start, IR[31:0], mem_ready           handshake into the sequencer
//     Rin[15:0], Rout[15:0]                one-hot register load/drive enables
//     PCout .. LOin                        single-bit datapath strobes
//     alu_op[13:0]                         one-hot ALU operation select
//     busy, done, illegal_op, mem_timeout  status
//     instr_count[31:0]                    only when INSTR_COUNT_EN is defined
interface alu_instr_sequencer_if;
    logic        start;
    logic [31:0] IR;
    logic        mem_ready;

    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        Zin;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;
    logic [13:0] alu_op;

    logic        busy;
    logic        done;
    logic        illegal_op;
    logic        mem_timeout;
`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    modport master (
        input  start, IR, mem_ready,
        output Rin, Rout, PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
               IRin, Yin, Zlowout, Zhighout, HIin, LOin, alu_op,
               busy, done, illegal_op, mem_timeout
`ifdef INSTR_COUNT_EN
        , output instr_count
`endif
    );

    modport slave (
        output start, IR, mem_ready,
        input  Rin, Rout, PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
               IRin, Yin, Zlowout, Zhighout, HIin, LOin, alu_op,
               busy, done, illegal_op, mem_timeout
`ifdef INSTR_COUNT_EN
        , input instr_count
`endif
    );
endinterface

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer
//   Hardwired control FSM. It steps the datapath through fetch (T0-T2) and
//   execute (T3-T6) for register-register ALU instructions.
//   Ports:
//     clock  rising-edge system clock
//     clear  synchronous active-high reset. It forces IDLE from any state.
//     bus    alu_instr_sequencer_if.master (handshake in, strobes/status out)
//   Parameter:
//     MEM_WAIT_MAX  number of T1 cycles with mem_ready low before the fetch
//                   aborts with a mem_timeout pulse (1..255)
//   Optional feature:
//     INSTR_COUNT_EN  when defined, bus.instr_count counts completed
//                     instructions. The counter is cleared by clear and
//                     wraps at 2^32.
module alu_instr_sequencer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    alu_instr_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_BINARY, CLS_LONG, CLS_UNARY, CLS_ILLEGAL
    } op_class_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t    state, next_state;
    logic [7:0] wait_cnt;
    logic      illegal_q, timeout_q;
    logic      illegal_set, timeout_set;

    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic [15:0] ra_sel, rb_sel, rc_sel;
    op_class_t   op_class;
    logic [13:0] alu_sel;

    logic [15:0] rin_c, rout_c;
    logic [13:0] alu_op_c;
    logic pc_out_c, mar_in_c, inc_pc_c, z_in_c, pc_in_c, read_c, mdr_in_c;
    logic mdr_out_c, ir_in_c, y_in_c, zlow_out_c, zhigh_out_c, hi_in_c, lo_in_c;

    // The low IR bits (immediate/unused field) are not used by these instructions.
    logic unused_ir_bits;
    assign unused_ir_bits = ^bus.IR[14:0];

    assign opcode = bus.IR[31:27];
    assign ra     = bus.IR[26:23];
    assign rb     = bus.IR[22:19];
    assign rc     = bus.IR[18:15];
    assign ra_sel = 16'd1 << ra;
    assign rb_sel = 16'd1 << rb;
    assign rc_sel = 16'd1 << rc;

    // Opcode classification and ALU select. The binary ops keep their opcode
    // as the alu_op bit. MUL/DIV sit above NEG/NOT in alu_op, which is the
    // reverse of their opcode order.
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_sel  = '0;
        case (opcode)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                op_class = CLS_BINARY;
                alu_sel  = 14'd1 << opcode;
            end
            5'd9: begin
                op_class = CLS_LONG;
                alu_sel  = 14'd1 << 11;
            end
            5'd10: begin
                op_class = CLS_LONG;
                alu_sel  = 14'd1 << 12;
            end
            5'd11: begin
                op_class = CLS_UNARY;
                alu_sel  = 14'd1 << 9;
            end
            5'd12: begin
                op_class = CLS_UNARY;
                alu_sel  = 14'd1 << 10;
            end
            default: begin
                op_class = CLS_ILLEGAL;
                alu_sel  = '0;
            end
        endcase
    end

    // State register, T1 wait counter and the two status pulse flags.
    // The wait counter counts consecutive T1 cycles with mem_ready low. It
    // reads zero only in the first T1 cycle, and that is what gates PCin.
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            wait_cnt  <= (state == T1 && !bus.mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            illegal_q <= illegal_set;
            timeout_q <= timeout_set;
        end
    end

    // Next-state and Moore strobe decode. If IR changes under an execute
    // state so that the class no longer matches, the FSM falls back to IDLE.
    always_comb begin
        next_state  = state;
        illegal_set = 1'b0;
        timeout_set = 1'b0;
        rin_c       = '0;
        rout_c      = '0;
        alu_op_c    = '0;
        pc_out_c    = 1'b0;
        mar_in_c    = 1'b0;
        inc_pc_c    = 1'b0;
        z_in_c      = 1'b0;
        pc_in_c     = 1'b0;
        read_c      = 1'b0;
        mdr_in_c    = 1'b0;
        mdr_out_c   = 1'b0;
        ir_in_c     = 1'b0;
        y_in_c      = 1'b0;
        zlow_out_c  = 1'b0;
        zhigh_out_c = 1'b0;
        hi_in_c     = 1'b0;
        lo_in_c     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) next_state = T0;
            end
            T0: begin
                pc_out_c   = 1'b1;
                mar_in_c   = 1'b1;
                inc_pc_c   = 1'b1;
                z_in_c     = 1'b1;
                next_state = T1;
            end
            T1: begin
                zlow_out_c = 1'b1;
                read_c     = 1'b1;
                mdr_in_c   = 1'b1;
                pc_in_c    = (wait_cnt == 8'd0);
                if (bus.mem_ready) begin
                    next_state = T2;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state  = IDLE;
                    timeout_set = 1'b1;
                end
            end
            T2: begin
                mdr_out_c  = 1'b1;
                ir_in_c    = 1'b1;
                next_state = T3;
            end
            T3: begin
                case (op_class)
                    CLS_BINARY, CLS_LONG: begin
                        rout_c     = rb_sel;
                        y_in_c     = 1'b1;
                        next_state = T4;
                    end
                    CLS_UNARY: begin
                        rout_c     = rb_sel;
                        alu_op_c   = alu_sel;
                        z_in_c     = 1'b1;
                        next_state = T4;
                    end
                    default: begin
                        next_state  = IDLE;
                        illegal_set = 1'b1;
                    end
                endcase
            end
            T4: begin
                case (op_class)
                    CLS_BINARY: begin
                        rout_c     = rc_sel;
                        alu_op_c   = alu_sel;
                        z_in_c     = 1'b1;
                        next_state = T5;
                    end
                    CLS_LONG: begin
                        rout_c     = ra_sel;
                        alu_op_c   = alu_sel;
                        z_in_c     = 1'b1;
                        next_state = T5;
                    end
                    CLS_UNARY: begin
                        zlow_out_c = 1'b1;
                        rin_c      = ra_sel;
                        next_state = DONE;
                    end
                    default: next_state = IDLE;
                endcase
            end
            T5: begin
                case (op_class)
                    CLS_BINARY: begin
                        zlow_out_c = 1'b1;
                        rin_c      = ra_sel;
                        next_state = DONE;
                    end
                    CLS_LONG: begin
                        zlow_out_c = 1'b1;
                        lo_in_c    = 1'b1;
                        next_state = T6;
                    end
                    default: next_state = IDLE;
                endcase
            end
            T6: begin
                zhigh_out_c = 1'b1;
                hi_in_c     = 1'b1;
                next_state  = DONE;
            end
            DONE: begin
                next_state = bus.start ? T0 : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.Rin         = rin_c;
    assign bus.Rout        = rout_c;
    assign bus.alu_op      = alu_op_c;
    assign bus.PCout       = pc_out_c;
    assign bus.MARin       = mar_in_c;
    assign bus.IncPC       = inc_pc_c;
    assign bus.Zin         = z_in_c;
    assign bus.PCin        = pc_in_c;
    assign bus.Read        = read_c;
    assign bus.MDRin       = mdr_in_c;
    assign bus.MDRout      = mdr_out_c;
    assign bus.IRin        = ir_in_c;
    assign bus.Yin         = y_in_c;
    assign bus.Zlowout     = zlow_out_c;
    assign bus.Zhighout    = zhigh_out_c;
    assign bus.HIin        = hi_in_c;
    assign bus.LOin        = lo_in_c;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.illegal_op  = illegal_q;
    assign bus.mem_timeout = timeout_q;

`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count_q;

    // Counts entries into DONE. Aborted fetches and illegal opcodes never
    // reach DONE, so they are not counted.
    always_ff @(posedge clock) begin
        if (clear) begin
            instr_count_q <= '0;
        end else if (next_state == DONE && state != DONE) begin
            instr_count_q <= instr_count_q + 32'd1;
        end
    end

    assign bus.instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer
//   Directed bench for alu_instr_sequencer. It drives IR/start/mem_ready
//   through the interface and compares the strobes seen in each state
//   against hand-derived values.
module tb_alu_instr_sequencer;

    logic clock;
    logic clear;
    int   checks    = 0;
    int   errors    = 0;
    bit   inv_armed = 1'b0;

    alu_instr_sequencer_if bus();

    alu_instr_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Strobe bit positions in the packed snapshot below.
    localparam logic [13:0] ST_PCOUT    = 14'h2000;
    localparam logic [13:0] ST_MARIN    = 14'h1000;
    localparam logic [13:0] ST_INCPC    = 14'h0800;
    localparam logic [13:0] ST_ZIN      = 14'h0400;
    localparam logic [13:0] ST_PCIN     = 14'h0200;
    localparam logic [13:0] ST_READ     = 14'h0100;
    localparam logic [13:0] ST_MDRIN    = 14'h0080;
    localparam logic [13:0] ST_MDROUT   = 14'h0040;
    localparam logic [13:0] ST_IRIN     = 14'h0020;
    localparam logic [13:0] ST_YIN      = 14'h0010;
    localparam logic [13:0] ST_ZLOWOUT  = 14'h0008;
    localparam logic [13:0] ST_ZHIGHOUT = 14'h0004;
    localparam logic [13:0] ST_HIIN     = 14'h0002;
    localparam logic [13:0] ST_LOIN     = 14'h0001;

    localparam logic [13:0] FETCH_T0 = ST_PCOUT | ST_MARIN | ST_INCPC | ST_ZIN;
    localparam logic [13:0] FETCH_T1 = ST_ZLOWOUT | ST_PCIN | ST_READ | ST_MDRIN;
    localparam logic [13:0] WAIT_T1  = ST_ZLOWOUT | ST_READ | ST_MDRIN;
    localparam logic [13:0] FETCH_T2 = ST_MDROUT | ST_IRIN;

    logic [13:0] strobes;
    assign strobes = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.PCin, bus.Read,
                      bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zlowout,
                      bus.Zhighout, bus.HIin, bus.LOin};

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [31:0] ir, input logic mr);
        bus.start     = s;
        bus.IR        = ir;
        bus.mem_ready = mr;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic checkStep(input string tag, input logic [13:0] e_str,
                             input logic [15:0] e_rin, input logic [15:0] e_rout,
                             input logic [13:0] e_alu, input logic e_busy,
                             input logic e_done);
        checkOutput({tag, "_strobes"}, 32'(strobes), 32'(e_str));
        checkOutput({tag, "_rin"},     32'(bus.Rin), 32'(e_rin));
        checkOutput({tag, "_rout"},    32'(bus.Rout), 32'(e_rout));
        checkOutput({tag, "_alu"},     32'(bus.alu_op), 32'(e_alu));
        checkOutput({tag, "_busy"},    32'(bus.busy), 32'(e_busy));
        checkOutput({tag, "_done"},    32'(bus.done), 32'(e_done));
    endtask

    // One-hot and single-bus-driver invariants, checked every cycle after reset.
    always @(negedge clock) begin
        if (inv_armed) begin
            checkOutput("inv_onehot",
                        {29'd0, $onehot0(bus.Rout), $onehot0(bus.Rin), $onehot0(bus.alu_op)},
                        32'h7);
            checkOutput("inv_bus_driver",
                        32'((32'(|bus.Rout) + 32'(bus.PCout) + 32'(bus.MDRout)
                             + 32'(bus.Zlowout) + 32'(bus.Zhighout)) <= 32'd1),
                        32'd1);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        clear = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0);
        tick();

        // Reset state
        checkStep("reset", '0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("reset_illegal", 32'(bus.illegal_op), 32'd0);
        checkOutput("reset_timeout", 32'(bus.mem_timeout), 32'd0);
`ifdef INSTR_COUNT_EN
        checkOutput("reset_count", bus.instr_count, 32'd0);
`endif
        clear     = 1'b0;
        inv_armed = 1'b1;

        // SHL R6 <- R0 << R8 (IR = 0x33040000), memory ready immediately
        applyStimulus(1'b1, 32'h33040000, 1'b1);
        tick();
        checkStep("shl_t0", FETCH_T0, '0, '0, '0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        checkStep("shl_t1", FETCH_T1, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("shl_t2", FETCH_T2, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("shl_t3", ST_YIN, '0, 16'h0001, '0, 1'b1, 1'b0);
        tick();
        checkStep("shl_t4", ST_ZIN, '0, 16'h0100, 14'h0040, 1'b1, 1'b0);
        tick();
        checkStep("shl_t5", ST_ZLOWOUT, 16'h0040, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("shl_done", '0, '0, '0, '0, 1'b1, 1'b1);
        tick();
        checkStep("shl_idle", '0, '0, '0, '0, 1'b0, 1'b0);

        // MUL Ra=2 Rb=3, start held high so DONE chains straight into a NEG
        applyStimulus(1'b1, mk_ir(5'd9, 4'd2, 4'd3, 4'd5), 1'b1);
        tick();
        checkStep("mul_t0", FETCH_T0, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("mul_t1", FETCH_T1, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("mul_t2", FETCH_T2, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("mul_t3", ST_YIN, '0, 16'h0008, '0, 1'b1, 1'b0);
        tick();
        checkStep("mul_t4", ST_ZIN, '0, 16'h0004, 14'h0800, 1'b1, 1'b0);
        tick();
        checkStep("mul_t5", ST_ZLOWOUT | ST_LOIN, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("mul_t6", ST_ZHIGHOUT | ST_HIIN, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("mul_done", '0, '0, '0, '0, 1'b1, 1'b1);
        bus.IR = mk_ir(5'd11, 4'd4, 4'd7, 4'd0);
        tick();
        checkStep("b2b_t0", FETCH_T0, '0, '0, '0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        checkStep("neg_t3", ST_ZIN, '0, 16'h0080, 14'h0200, 1'b1, 1'b0);
        tick();
        checkStep("neg_t4", ST_ZLOWOUT, 16'h0010, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("neg_done", '0, '0, '0, '0, 1'b1, 1'b1);
        tick();
        checkStep("neg_idle", '0, '0, '0, '0, 1'b0, 1'b0);

        // SUB R1 <- R2 - R3 with mem_ready low for three T1 cycles
        applyStimulus(1'b1, mk_ir(5'd1, 4'd1, 4'd2, 4'd3), 1'b0);
        tick();
        checkStep("wait_t0", FETCH_T0, '0, '0, '0, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick();
        checkStep("wait_t1_c1", FETCH_T1, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("wait_t1_c2", WAIT_T1, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("wait_t1_c3", WAIT_T1, '0, '0, '0, 1'b1, 1'b0);
        tick();
        bus.mem_ready = 1'b1;
        checkStep("wait_t1_c4", WAIT_T1, '0, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("wait_t2", FETCH_T2, '0, '0, '0, 1'b1, 1'b0);
        tick();
        tick();
        checkStep("sub_t4", ST_ZIN, '0, 16'h0008, 14'h0002, 1'b1, 1'b0);
        tick();
        checkStep("sub_t5", ST_ZLOWOUT, 16'h0002, '0, '0, 1'b1, 1'b0);
        tick();
        checkStep("sub_done", '0, '0, '0, '0, 1'b1, 1'b1);
`ifdef INSTR_COUNT_EN
        checkOutput("count_after_four", bus.instr_count, 32'd4);
`endif
        tick();

        // Fetch timeout: mem_ready never arrives. The 15th low T1 cycle aborts.
        applyStimulus(1'b1, mk_ir(5'd0, 4'd1, 4'd1, 4'd1), 1'b0);
        tick();
        bus.start = 1'b0;
        tick();
        checkStep("to_t1_c1", FETCH_T1, '0, '0, '0, 1'b1, 1'b0);
        for (int i = 2; i <= 15; i++) tick();
        checkStep("to_t1_c15", WAIT_T1, '0, '0, '0, 1'b1, 1'b0);
        checkOutput("to_pulse_early", 32'(bus.mem_timeout), 32'd0);
        tick();
        checkStep("to_idle", '0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("to_pulse", 32'(bus.mem_timeout), 32'd1);
        tick();
        checkOutput("to_pulse_end", 32'(bus.mem_timeout), 32'd0);

        // Illegal opcode 11111
        applyStimulus(1'b1, mk_ir(5'd31, 4'd1, 4'd2, 4'd3), 1'b1);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        checkStep("ill_t3", '0, '0, '0, '0, 1'b1, 1'b0);
        checkOutput("ill_pulse_early", 32'(bus.illegal_op), 32'd0);
        tick();
        checkStep("ill_idle", '0, '0, '0, '0, 1'b0, 1'b0);
        checkOutput("ill_pulse", 32'(bus.illegal_op), 32'd1);
        tick();
        checkOutput("ill_pulse_end", 32'(bus.illegal_op), 32'd0);
`ifdef INSTR_COUNT_EN
        checkOutput("count_after_aborts", bus.instr_count, 32'd4);
`endif

        // clear asserted in T4 of a SHL
        applyStimulus(1'b1, 32'h33040000, 1'b1);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checkStep("clr_t4", ST_ZIN, '0, 16'h0100, 14'h0040, 1'b1, 1'b0);
        clear = 1'b1;
        tick();
        checkStep("clr_idle", '0, '0, '0, '0, 1'b0, 1'b0);
`ifdef INSTR_COUNT_EN
        checkOutput("clr_count", bus.instr_count, 32'd0);
`endif
        clear = 1'b0;
        tick();
        checkStep("clr_stay", '0, '0, '0, '0, 1'b0, 1'b0);

        inv_armed = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
